// File: rtl/fetch_resp_pkg.sv
// Shared types and helpers for the fetch responder: FSM state encoding,
// the stall LFSR tap mask, and the address-derived line pattern.
package fetch_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits 15..0
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Line width produced by line_pattern
    localparam int LINE_W = 128;

    // One 32-bit word of the line: line-aligned base plus 4*word index, keyed
    function automatic logic [31:0] pattern_word(
        input logic [31:0] addr,
        input logic [31:0] word_idx,
        input logic [31:0] key
    );
        return ((addr & 32'hFFFF_FFF0) + (word_idx << 2)) ^ key;
    endfunction

    // Full response line for a byte address
    function automatic logic [LINE_W-1:0] line_pattern(
        input logic [31:0] addr,
        input logic [31:0] key
    );
        logic [LINE_W-1:0] line;
        line = '0;
        for (int k = 0; k < LINE_W / 32; k++) begin
            line[32*k +: 32] = pattern_word(addr, 32'(k), key);
        end
        return line;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with a reset seed and an advance enable.
module lfsr16
    import fetch_resp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] lfsr_state
);

    // Shift left, feeding back the XOR of the tapped bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_state <= SEED;
        end else if (en) begin
            lfsr_state <= {lfsr_state[14:0], ^(lfsr_state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/fetch_resp_128.sv
// Responder end of the 128-bit fetch req/gnt/rvalid protocol: grants with
// bounded pseudo-random stalls, returns an address-derived line after a fixed
// latency, and flags initiator protocol violations.
module fetch_resp_128
    import fetch_resp_pkg::*;
#(
    parameter int          FETCH_ADDR_WIDTH = 32,
    parameter int          FETCH_DATA_WIDTH = 128,
    parameter int          RESP_LATENCY     = 2,
    parameter logic [31:0] PATTERN_KEY      = 32'hA5A5_0000,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_req_i,
    input  logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                        fetch_gnt_o,
    output logic                        fetch_rvalid_o,
    output logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_o,
    input  logic                        stall_en_i,
    output logic [31:0]                 trans_cnt_o,
    output logic                        proto_err_o
);

    localparam int         NUM_WORDS = FETCH_DATA_WIDTH / 32;
    localparam logic [3:0] LAT_INIT  = (RESP_LATENCY >= 2) ? 4'(RESP_LATENCY - 2) : 4'd0;

    fetch_state_t                state_reg, state_next;
    logic [3:0]                  lat_cnt_reg, lat_cnt_next;
    logic [1:0]                  stall_cnt_reg;
    logic [FETCH_ADDR_WIDTH-1:0] addr_reg;
    logic [FETCH_ADDR_WIDTH-1:0] pend_addr_reg;
    logic                        req_pend_reg;
    logic [15:0]                 lfsr;
    logic                        grant_window;
    logic                        stall;
    logic                        gnt;
    logic [FETCH_ADDR_WIDTH-1:0] pat_addr;
    logic [31:0]                 pat_addr32;
    logic [FETCH_DATA_WIDTH-1:0] pat_line;
    logic                        unused_lfsr_bits;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (1'b1),
        .lfsr_state (lfsr)
    );

    // Only the low two LFSR bits steer stalls
    assign unused_lfsr_bits = ^lfsr[15:2];

    // Grant decision: window open, not stalled, never during reset
    always_comb begin
        grant_window = (state_reg == IDLE) || (state_reg == RESP);
        stall        = stall_en_i && (lfsr[1:0] == 2'b00) && (stall_cnt_reg < 2'd3);
        gnt          = rst_n && fetch_req_i && grant_window && !stall;
        fetch_gnt_o  = gnt;
    end

    // Next-state logic; a grant in IDLE or RESP takes the accept path
    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (gnt) begin
                    if (RESP_LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next   = LAT;
                        lat_cnt_next = LAT_INIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            LAT: begin
                if (lat_cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line entering RESP comes from the live address when granting with
    // single-cycle latency, otherwise from the captured address
    assign pat_addr = gnt ? fetch_addr_i : addr_reg;

    generate
        if (FETCH_ADDR_WIDTH >= 32) begin : g_addr_trunc
            assign pat_addr32 = pat_addr[31:0];
            if (FETCH_ADDR_WIDTH > 32) begin : g_addr_hi
                logic unused_addr_hi;
                assign unused_addr_hi = ^pat_addr[FETCH_ADDR_WIDTH-1:32];
            end
        end else begin : g_addr_ext
            assign pat_addr32 = {{(32 - FETCH_ADDR_WIDTH){1'b0}}, pat_addr};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            assign pat_line[32*gi +: 32] = pattern_word(pat_addr32, 32'(gi), PATTERN_KEY);
        end
    endgenerate

    // FSM state, latency counter and captured request address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 4'd0;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            if (gnt) begin
                addr_reg <= fetch_addr_i;
            end
        end
    end

    // Count consecutive stalled cycles so a grant is forced after three
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= 2'd0;
        end else if (gnt) begin
            stall_cnt_reg <= 2'd0;
        end else if (fetch_req_i && grant_window && stall) begin
            stall_cnt_reg <= stall_cnt_reg + 2'd1;
        end
    end

    // Registered response: valid and data load on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_rvalid_o <= 1'b0;
            fetch_rdata_o  <= '0;
        end else begin
            fetch_rvalid_o <= (state_next == RESP);
            fetch_rdata_o  <= (state_next == RESP) ? pat_line : '0;
        end
    end

    // Completed-response counter, stepped once per RESP cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trans_cnt_o <= 32'd0;
        end else if (state_reg == RESP) begin
            trans_cnt_o <= trans_cnt_o + 32'd1;
        end
    end

    // Sticky error when a waiting request is withdrawn or changes address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pend_reg  <= 1'b0;
            pend_addr_reg <= '0;
            proto_err_o   <= 1'b0;
        end else begin
            if (req_pend_reg && (!fetch_req_i || (fetch_addr_i != pend_addr_reg))) begin
                proto_err_o <= 1'b1;
            end
            req_pend_reg  <= fetch_req_i && !gnt;
            pend_addr_reg <= fetch_addr_i;
        end
    end

endmodule

// File: tb/tb_fetch_resp_128.sv
// Randomized bench for fetch_resp_128 with a due-cycle scoreboard model.
module tb_fetch_resp_128;
    import fetch_resp_pkg::*;

    localparam int          LATENCY = 2;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [31:0]  addr;
    logic         stall_en;
    logic         gnt;
    logic         rvalid;
    logic [127:0] rdata;
    logic [31:0]  trans_cnt;
    logic         proto_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: one outstanding transaction tracked by due cycle
    int unsigned m_cyc;
    logic [15:0] m_lfsr;
    int          m_scnt;
    bit          m_out;
    int unsigned m_due;
    logic [31:0] m_addr;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_err;
    logic [31:0] m_cnt;
    bit          obs_gnt;

    fetch_resp_128 #(
        .FETCH_ADDR_WIDTH (32),
        .FETCH_DATA_WIDTH (128),
        .RESP_LATENCY     (LATENCY),
        .PATTERN_KEY      (KEY),
        .LFSR_SEED        (SEED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req_i    (req),
        .fetch_addr_i   (addr),
        .fetch_gnt_o    (gnt),
        .fetch_rvalid_o (rvalid),
        .fetch_rdata_o  (rdata),
        .stall_en_i     (stall_en),
        .trans_cnt_o    (trans_cnt),
        .proto_err_o    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_lfsr      = SEED;
        m_scnt      = 0;
        m_out       = 1'b0;
        m_due       = 0;
        m_addr      = '0;
        m_pend      = 1'b0;
        m_pend_addr = '0;
        m_err       = 1'b0;
        m_cnt       = '0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, move to next cycle
    task automatic cycle();
        bit           resp_now;
        bit           win;
        bit           stall_m;
        bit           exp_g;
        logic [127:0] exp_line;
        @(negedge clk);
        resp_now = m_out && (m_cyc == m_due);
        win      = !m_out || resp_now;
        stall_m  = stall_en && (m_lfsr[1:0] == 2'b00) && (m_scnt < 3);
        exp_g    = rst_n && req && win && !stall_m;
        exp_line = resp_now ? line_pattern(m_addr, KEY) : 128'd0;
        check_value("gnt", {127'd0, gnt}, {127'd0, exp_g});
        check_value("rvalid", {127'd0, rvalid}, {127'd0, resp_now});
        check_value("rdata", rdata, exp_line);
        check_value("trans_cnt", {96'd0, trans_cnt}, {96'd0, m_cnt});
        check_value("proto_err", {127'd0, proto_err}, {127'd0, m_err});
        obs_gnt = gnt;
        if (resp_now) $display("resp #%0d addr=%h rdata=%h", m_cnt + 1, m_addr, rdata);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_pend && (!req || addr != m_pend_addr)) m_err = 1'b1;
            m_pend      = req && !exp_g;
            m_pend_addr = addr;
            if (resp_now) m_cnt = m_cnt + 32'd1;
            if (exp_g) begin
                m_out  = 1'b1;
                m_due  = m_cyc + LATENCY;
                m_addr = addr;
                m_scnt = 0;
            end else begin
                if (resp_now) m_out = 1'b0;
                if (req && win && stall_m) m_scnt++;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Raise a request and hold it until the responder grants it
    task automatic issue_req(input logic [31:0] a, input bit hold);
        int waited = 0;
        bit got = 1'b0;
        req  = 1'b1;
        addr = a;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            if (obs_gnt) got = 1'b1;
            else waited++;
        end
        check_value("gnt_seen", {127'd0, got}, 128'd1);
        if (stall_en) check_value("gnt_wait_bound", {127'd0, waited <= LATENCY + 2}, 128'd1);
        if (!hold) req = 1'b0;
    endtask

    // Idle until the model predicts the next request will be stalled
    task automatic wait_stall_slot();
        bit found = 1'b0;
        req = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!m_out && m_lfsr[1:0] == 2'b00 && m_scnt < 3) found = 1'b1;
            else cycle();
        end
        check_value("stall_slot", {127'd0, found}, 128'd1);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned c0;
        int          n;
        logic [31:0] a;

        rst_n    = 1'b0;
        req      = 1'b1;
        addr     = '0;
        stall_en = 1'b0;
        m_cyc    = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset values with req held high
        for (int i = 0; i < 3; i++) cycle();
        check_value("reset_gnt", {127'd0, gnt}, 128'd0);
        rst_n = 1'b1;
        req   = 1'b0;
        idle(2);

        // Single fetch, no stall
        issue_req(32'h0000_0124, 1'b0);
        cycle();
        check_value("single_rvalid", {127'd0, rvalid}, 128'd1);
        check_value("single_rdata", rdata, 128'hA5A5012C_A5A50128_A5A50124_A5A50120);
        cycle();
        check_value("single_cnt", {96'd0, trans_cnt}, 128'd1);
        idle(2);

        // Back-to-back with req held
        issue_req(32'h0, 1'b1);
        c0 = m_cyc;
        issue_req(32'h10, 1'b1);
        issue_req(32'h20, 1'b0);
        check_value("b2b_span", 128'(m_cyc - c0), 128'(2 * LATENCY));
        idle(LATENCY + 1);
        check_value("b2b_cnt", {96'd0, trans_cnt}, 128'd4);

        // Random stalls, random addresses, random gaps
        stall_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            issue_req(a, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(LATENCY + 2);
        check_value("random_perr", {127'd0, proto_err}, 128'd0);

        // Withdraw a stalled request
        wait_stall_slot();
        req  = 1'b1;
        addr = 32'h0000_5000;
        cycle();
        req = 1'b0;
        cycle();
        check_value("perr_drop", {127'd0, proto_err}, 128'd1);
        idle(3);
        check_value("perr_sticky", {127'd0, proto_err}, 128'd1);
        do_reset(2);
        check_value("perr_cleared", {127'd0, proto_err}, 128'd0);

        // Change address while pending
        wait_stall_slot();
        req  = 1'b1;
        addr = 32'h0000_6000;
        cycle();
        addr = 32'h0000_6040;
        cycle();
        check_value("perr_addr", {127'd0, proto_err}, 128'd1);
        idle(LATENCY + 2);
        do_reset(2);

        // Reset one cycle after a grant drops the transaction
        stall_en = 1'b0;
        issue_req(32'h0000_0300, 1'b0);
        do_reset(1);
        check_value("rst_drop_rvalid", {127'd0, rvalid}, 128'd0);
        idle(3);
        check_value("rst_drop_cnt", {96'd0, trans_cnt}, 128'd0);
        issue_req(32'h0000_0400, 1'b0);
        n = 1;
        while (!rvalid && n < 20) begin
            cycle();
            n++;
        end
        check_value("rst_latency", 128'(n), 128'(LATENCY));
        idle(3);
        check_value("rst_after_cnt", {96'd0, trans_cnt}, 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_resp_128.md
Name: fetch_resp_128

Overview:
- Responder (slave) end of the 128-bit instruction-fetch req/gnt/rvalid protocol.
- Grants requests with pseudo-random, bounded stalls. Returns a deterministic, address-derived 128-bit line after a fixed latency.
- Flags initiator protocol violations.
- Sits in the ICache testbench in place of L2/memory. It is synthesizable so it can also run on emulation targets.

Parameters:
- FETCH_ADDR_WIDTH, 32, fetch address width.
- FETCH_DATA_WIDTH, 128, line width; must be a multiple of 32.
- RESP_LATENCY, 2, cycles from grant edge to rvalid; legal range 1..15.
- PATTERN_KEY, 32'hA5A5_0000, XOR key for data words.
- LFSR_SEED, 16'hACE1, stall LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fetch_req_i  in  1  request
- fetch_addr_i  in  FETCH_ADDR_WIDTH  request byte address
- fetch_gnt_o  out  1  grant (combinational from req/state/LFSR)
- fetch_rvalid_o  out  1  response valid, single-cycle pulse
- fetch_rdata_o  out  FETCH_DATA_WIDTH  response line
- stall_en_i  in  1  enables random grant stalls
- trans_cnt_o  out  32  number of completed responses
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- **Clock and reset.** One clock: clk. Reset rst_n is synchronous and active-low; it is sampled only at posedge clk. While rst_n=0 at a posedge, the following values load:
  - state=IDLE
  - fetch_rvalid_o=0, fetch_rdata_o=0
  - trans_cnt_o=0, proto_err_o=0
  - lfsr=LFSR_SEED, stall_cnt=0, lat_cnt=0
- **Grant during reset.** fetch_gnt_o is forced 0 while rst_n=0.
- **Reset mid-operation.** Any pending transaction is dropped; no rvalid is issued for it.
- **Outstanding limit.** One transaction outstanding.
- **Grant windows.** A grant is allowed only in IDLE, or in RESP (back-to-back: new grant in the same cycle as rvalid).
- **Grant rule.** fetch_gnt_o = fetch_req_i & (state∈{IDLE,RESP}) & ~stall.
  - stall = stall_en_i & (lfsr[1:0]==2'b00) & (stall_cnt<3).
  - Worst case is therefore 3 stalled cycles, then a forced grant.
- **Stall counter.** stall_cnt increments on each cycle with req high, a grant window, and stall. It clears on grant.
- **LFSR.** 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset.
- **Accept.** On the grant edge, addr_q <= fetch_addr_i.
  - If RESP_LATENCY==1: next state is RESP.
  - Else: next state is LAT with lat_cnt=RESP_LATENCY-2.
- **LAT.** Decrements lat_cnt; moves to RESP when lat_cnt==0.
- **Latency.** Grant sampled at edge t; fetch_rvalid_o=1 during cycle t+RESP_LATENCY.
- **RESP.**
  - fetch_rvalid_o=1 and trans_cnt_o increments (wraps at 2^32).
  - Next state: accept path if granted, else IDLE.
- **Registered outputs.** fetch_rvalid_o and fetch_rdata_o are registered and loaded on the edge entering RESP.
- **Data pattern.** base = {addr_q[FETCH_ADDR_WIDTH-1:4],4'b0}. Word k (bits 32k+31:32k) = (base + 4k) ^ PATTERN_KEY, for k=0..FETCH_DATA_WIDTH/32-1. Addition is modulo 2^32.
- **rdata when not valid.** fetch_rdata_o=0 whenever fetch_rvalid_o=0.
- **Protocol errors.** A req_pend flag is set when req=1 and gnt=0 at an edge. proto_err_o is set if, on the following cycle, either:
  - fetch_req_i==0 (request withdrawn), or
  - fetch_addr_i differs from the captured pending address.
- **Request outside a grant window.** A request while in LAT is legal: it waits, with no error.

Decomposition:
- Package fetch_resp_pkg holds:
  - state enum {IDLE, LAT, RESP} (logic [1:0])
  - LFSR tap constant
  - function line_pattern(addr, key) returning the data line
- The TB checker imports line_pattern so DUT and scoreboard share one definition.
- Sub-module lfsr16 (seed parameter, enable, 16-bit state output). It is reused by other TB stimulus blocks.

Test Plan:
- **Reset values.** rst_n=0 for 3 cycles with req=1 → gnt=0, rvalid=0, rdata=0, trans_cnt=0, proto_err=0.
- **Single fetch, no stall.** stall_en=0, RESP_LATENCY=2, req with addr 0x0000_0124 → gnt same cycle; rvalid exactly 2 cycles later; rdata words = 0x120,0x124,0x128,0x12C each ^0xA5A5_0000; trans_cnt=1.
- **Back-to-back.** req held high, addrs 0x0,0x10,0x20 → each new gnt coincides with prior rvalid; 3 responses in 3×RESP_LATENCY cycles; trans_cnt=3.
- **Random stalls.** stall_en=1, 1000 requests → no gnt wait exceeds 3 cycles; every response matches line_pattern; proto_err=0.
- **Protocol violations.**
  - Force a stall, then drop req before gnt → proto_err=1 next cycle and stays 1.
  - Separately, change addr while pending → proto_err=1.
- **Reset mid-operation.** Assert rst_n=0 one cycle after a grant → no rvalid for that transaction; after release, a new req is granted with latency RESP_LATENCY.
